// File: rtl/idli_trace_m.sv
// Retirement tracer: builds one record per retired instruction from EX events and
// queues it in a vld/rdy FIFO. Optional per-record timestamps with IDLI_TRACE_TSTAMP_EN.
module idli_trace_m #(
    parameter int NUM_REGS = 16,
    parameter int NUM_PINS = 4,
    parameter int DEPTH    = 8,
    parameter int SEQ_W    = 8,
    parameter int DROP_W   = 8
) (
    input  logic                        i_trc_gck,
    input  logic                        i_trc_rst_n,
    input  logic [1:0]                  i_trc_ctr,
    input  logic                        i_trc_new,
    input  logic [15:0]                 i_trc_pc,
    input  logic                        i_trc_reg_wr,
    input  logic [$clog2(NUM_REGS)-1:0] i_trc_reg_idx,
    input  logic                        i_trc_pred_wr,
    input  logic                        i_trc_pred_val,
    input  logic                        i_trc_pin_wr,
    input  logic [$clog2(NUM_PINS)-1:0] i_trc_pin_idx,
    input  logic                        i_trc_done,
    output logic                        o_trc_vld,
    input  logic                        i_trc_rdy,
    output logic [15:0]                 o_trc_pc,
    output logic [NUM_REGS-1:0]         o_trc_regs,
    output logic [1:0]                  o_trc_pred,
    output logic [NUM_PINS-1:0]         o_trc_pins,
    output logic [SEQ_W-1:0]            o_trc_seq,
`ifdef IDLI_TRACE_TSTAMP_EN
    output logic [31:0]                 o_trc_tstamp,
`endif
    output logic                        o_trc_ovf,
    output logic [DROP_W-1:0]           o_trc_drops
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [15:0]         pc;
        logic [NUM_REGS-1:0] regs;
        logic [1:0]          pred;
        logic [NUM_PINS-1:0] pins;
        logic [SEQ_W-1:0]    seq;
`ifdef IDLI_TRACE_TSTAMP_EN
        logic [31:0]         tstamp;
`endif
    } rec_t;

    logic [15:0]         pc_q, pc_d;
    logic [NUM_REGS-1:0] regs_q, regs_d;
    logic [1:0]          pred_q, pred_d;
    logic [NUM_PINS-1:0] pins_q, pins_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d;
    logic [DROP_W-1:0]   drops_q, drops_d;
    rec_t                mem_q [DEPTH];
    rec_t                mem_d [DEPTH];
`ifdef IDLI_TRACE_TSTAMP_EN
    logic [31:0]         tstamp_q, tstamp_d;
`endif

    logic       empty, full, done_acc, pop, wr_en;
    logic [AW-1:0] head_idx;
    rec_t       new_rec, head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign done_acc = i_trc_done && (i_trc_ctr == 2'd3);
    assign pop      = !empty && i_trc_rdy;
    // A full FIFO still accepts a push when the head is leaving the same cycle.
    assign wr_en    = done_acc && (!full || pop);

    always_comb begin
        new_rec      = '0;
        new_rec.pc   = pc_q;
        new_rec.regs = regs_q;
        new_rec.pred = pred_q;
        new_rec.pins = pins_q;
        new_rec.seq  = seq_q;
`ifdef IDLI_TRACE_TSTAMP_EN
        new_rec.tstamp = tstamp_q;
`endif
    end

    always_comb begin
        pc_d     = pc_q;
        regs_d   = regs_q;
        pred_d   = pred_q;
        pins_d   = pins_q;
        seq_d    = seq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        drops_d  = drops_q;
        mem_d    = mem_q;
`ifdef IDLI_TRACE_TSTAMP_EN
        tstamp_d = tstamp_q + 32'd1;
`endif
        if (done_acc) begin
            pc_d   = '0;
            regs_d = '0;
            pred_d = '0;
            pins_d = '0;
            seq_d  = seq_q + SEQ_W'(1);
        end else if (i_trc_ctr == 2'd0) begin
            if (i_trc_new) pc_d = i_trc_pc;
            if (i_trc_reg_wr && (i_trc_reg_idx != '0)) regs_d[i_trc_reg_idx] = 1'b1;
            if (i_trc_pred_wr) pred_d = {1'b1, i_trc_pred_val};
            if (i_trc_pin_wr) pins_d[i_trc_pin_idx] = 1'b1;
        end
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = new_rec;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (done_acc) begin
            ovf_d = 1'b1;
            if (drops_q != '1) drops_d = drops_q + DROP_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge i_trc_gck) begin
        if (!i_trc_rst_n) begin
            pc_q     <= '0;
            regs_q   <= '0;
            pred_q   <= '0;
            pins_q   <= '0;
            seq_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            drops_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef IDLI_TRACE_TSTAMP_EN
            tstamp_q <= '0;
`endif
        end else begin
            pc_q     <= pc_d;
            regs_q   <= regs_d;
            pred_q   <= pred_d;
            pins_q   <= pins_d;
            seq_q    <= seq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            drops_q  <= drops_d;
            mem_q    <= mem_d;
`ifdef IDLI_TRACE_TSTAMP_EN
            tstamp_q <= tstamp_d;
`endif
        end
    end

    // When empty, show the slot just popped so the head holds its last value.
    assign head_idx = empty ? (rd_ptr_q[AW-1:0] - AW'(1)) : rd_ptr_q[AW-1:0];
    assign head     = mem_q[head_idx];

    assign o_trc_vld   = !empty;
    assign o_trc_pc    = head.pc;
    assign o_trc_regs  = head.regs;
    assign o_trc_pred  = head.pred;
    assign o_trc_pins  = head.pins;
    assign o_trc_seq   = head.seq;
    assign o_trc_ovf   = ovf_q;
    assign o_trc_drops = drops_q;
`ifdef IDLI_TRACE_TSTAMP_EN
    assign o_trc_tstamp = head.tstamp;
`endif

endmodule

// File: tb/tb_idli_trace_m.sv
// Directed bench for idli_trace_m: scoreboard capture, ctr gating, FIFO
// latency/handshake, overflow, saturation and reset.
module tb_idli_trace_m;

    logic        i_trc_gck = 1'b0;
    logic        i_trc_rst_n;
    logic [1:0]  i_trc_ctr;
    logic        i_trc_new;
    logic [15:0] i_trc_pc;
    logic        i_trc_reg_wr;
    logic [3:0]  i_trc_reg_idx;
    logic        i_trc_pred_wr;
    logic        i_trc_pred_val;
    logic        i_trc_pin_wr;
    logic [1:0]  i_trc_pin_idx;
    logic        i_trc_done;
    logic        o_trc_vld;
    logic        i_trc_rdy;
    logic [15:0] o_trc_pc;
    logic [15:0] o_trc_regs;
    logic [1:0]  o_trc_pred;
    logic [3:0]  o_trc_pins;
    logic [7:0]  o_trc_seq;
    logic        o_trc_ovf;
    logic [7:0]  o_trc_drops;
`ifdef IDLI_TRACE_TSTAMP_EN
    logic [31:0] o_trc_tstamp;
    logic [31:0] prev_ts;
`endif

    int checks = 0;
    int failures = 0;
    bit vpre;

    idli_trace_m dut (
        .i_trc_gck(i_trc_gck), .i_trc_rst_n(i_trc_rst_n), .i_trc_ctr(i_trc_ctr),
        .i_trc_new(i_trc_new), .i_trc_pc(i_trc_pc), .i_trc_reg_wr(i_trc_reg_wr),
        .i_trc_reg_idx(i_trc_reg_idx), .i_trc_pred_wr(i_trc_pred_wr),
        .i_trc_pred_val(i_trc_pred_val), .i_trc_pin_wr(i_trc_pin_wr),
        .i_trc_pin_idx(i_trc_pin_idx), .i_trc_done(i_trc_done), .o_trc_vld(o_trc_vld),
        .i_trc_rdy(i_trc_rdy), .o_trc_pc(o_trc_pc), .o_trc_regs(o_trc_regs),
        .o_trc_pred(o_trc_pred), .o_trc_pins(o_trc_pins), .o_trc_seq(o_trc_seq),
`ifdef IDLI_TRACE_TSTAMP_EN
        .o_trc_tstamp(o_trc_tstamp),
`endif
        .o_trc_ovf(o_trc_ovf), .o_trc_drops(o_trc_drops)
    );

    always #5 i_trc_gck = ~i_trc_gck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_trc_gck);
        #1;
    endtask

    task automatic idle_inputs();
        i_trc_new = 0; i_trc_pc = 0; i_trc_reg_wr = 0; i_trc_reg_idx = 0;
        i_trc_pred_wr = 0; i_trc_pred_val = 0; i_trc_pin_wr = 0; i_trc_pin_idx = 0;
        i_trc_done = 0;
    endtask

    task automatic do_reset();
        i_trc_rst_n = 0; i_trc_rdy = 0; i_trc_ctr = 1; idle_inputs();
        step(); step();
        i_trc_rst_n = 1;
    endtask

    // One instruction: events at ctr 0, retire at ctr 3. vld_pre is o_trc_vld
    // just before the push edge; rdy3 is rdy during the retire cycle only.
    task automatic instr(input logic [15:0] pc, input bit rw, input logic [3:0] ri,
                         input bit pw, input bit pv, input bit nw, input logic [1:0] ni,
                         input bit rdy3, output bit vld_pre);
        idle_inputs(); i_trc_rdy = 0;
        i_trc_ctr = 0; i_trc_new = 1; i_trc_pc = pc;
        i_trc_reg_wr = rw; i_trc_reg_idx = ri;
        i_trc_pred_wr = pw; i_trc_pred_val = pv; i_trc_pin_wr = nw; i_trc_pin_idx = ni;
        step();
        idle_inputs();
        i_trc_ctr = 1; step();
        i_trc_ctr = 2; step();
        i_trc_ctr = 3; i_trc_done = 1; i_trc_rdy = rdy3;
        vld_pre = o_trc_vld;
        step();
        i_trc_done = 0; i_trc_rdy = 0; i_trc_ctr = 1;
    endtask

    task automatic pop_one();
        i_trc_rdy = 1; step(); i_trc_rdy = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_vld", o_trc_vld, 0);
        chk("rst_pc", o_trc_pc, 0);
        chk("rst_regs", o_trc_regs, 0);
        chk("rst_pred", o_trc_pred, 0);
        chk("rst_pins", o_trc_pins, 0);
        chk("rst_seq", o_trc_seq, 0);
        chk("rst_ovf", o_trc_ovf, 0);
        chk("rst_drops", o_trc_drops, 0);

        // idle ctr loop, nothing retires
        for (int i = 0; i < 8; i++) begin
            i_trc_ctr = 2'(i); step();
            chk("idle_vld", o_trc_vld, 0);
        end
        chk("idle_drops", o_trc_drops, 0);
        chk("idle_ovf", o_trc_ovf, 0);

        // single record, one-cycle latency
        instr(16'h0040, 1, 4'd3, 0, 0, 0, 0, 0, vpre);
        chk("t1_vld_pre", vpre, 0);
        chk("t1_vld", o_trc_vld, 1);
        chk("t1_pc", o_trc_pc, 16'h0040);
        chk("t1_regs", o_trc_regs, 16'h0008);
        chk("t1_pred", o_trc_pred, 0);
        chk("t1_pins", o_trc_pins, 0);
        chk("t1_seq", o_trc_seq, 0);
        pop_one();
        chk("t1_empty", o_trc_vld, 0);
        chk("t1_hold_pc", o_trc_pc, 16'h0040);

        // two records, scoreboard cleared in between
        do_reset();
        instr(16'h0010, 0, 0, 1, 1, 0, 0, 0, vpre);
        instr(16'h0014, 0, 0, 0, 0, 1, 2'd2, 0, vpre);
        chk("t2_seq0", o_trc_seq, 0);
        chk("t2_pred0", o_trc_pred, 2'b11);
        chk("t2_pins0", o_trc_pins, 0);
        pop_one();
        chk("t2_vld1", o_trc_vld, 1);
        chk("t2_seq1", o_trc_seq, 1);
        chk("t2_pc1", o_trc_pc, 16'h0014);
        chk("t2_pred1", o_trc_pred, 2'b00);
        chk("t2_pins1", o_trc_pins, 4'b0100);
        pop_one();

        // reg index 0 is never recorded
        instr(16'h0020, 1, 4'd0, 0, 0, 0, 0, 0, vpre);
        chk("t3_regs", o_trc_regs, 0);
        pop_one();

        // events off ctr 0 and done off ctr 3 are ignored
        do_reset();
        i_trc_ctr = 1; i_trc_new = 1; i_trc_pc = 16'hdead; i_trc_reg_wr = 1; i_trc_reg_idx = 5;
        i_trc_pred_wr = 1; i_trc_pin_wr = 1; i_trc_done = 1;
        step();
        i_trc_ctr = 2; step();
        idle_inputs();
        chk("t4_nodone", o_trc_vld, 0);
        instr(16'h0080, 0, 0, 0, 0, 0, 0, 0, vpre);
        chk("t4_pc", o_trc_pc, 16'h0080);
        chk("t4_regs", o_trc_regs, 0);
        chk("t4_pred", o_trc_pred, 0);
        chk("t4_pins", o_trc_pins, 0);
        chk("t4_seq", o_trc_seq, 0);

        // overflow: 10 retired, 8 kept
        do_reset();
        for (int i = 0; i < 10; i++)
            instr(16'h0100 + 16'(i), 1, 4'(i + 1), 0, 0, 0, 0, 0, vpre);
        chk("t5_ovf", o_trc_ovf, 1);
        chk("t5_drops", o_trc_drops, 2);
        for (int i = 0; i < 8; i++) begin
            chk("t5_dvld", o_trc_vld, 1);
            chk("t5_dseq", o_trc_seq, 32'(i));
            chk("t5_dpc", o_trc_pc, 32'h0100 + 32'(i));
            chk("t5_dregs", o_trc_regs, 32'h1 << (i + 1));
`ifdef IDLI_TRACE_TSTAMP_EN
            if (i > 0) chk("t5_tstamp", o_trc_tstamp - prev_ts, 4);
            prev_ts = o_trc_tstamp;
`endif
            pop_one();
        end
        chk("t5_drained", o_trc_vld, 0);
        instr(16'h0200, 0, 0, 0, 0, 0, 0, 0, vpre);
        chk("t5_nextseq", o_trc_seq, 10);
        pop_one();

        // full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) instr(16'h0300 + 16'(i), 0, 0, 0, 0, 0, 0, 0, vpre);
        instr(16'h0308, 0, 0, 0, 0, 0, 0, 1, vpre);
        chk("t6_vld", o_trc_vld, 1);
        chk("t6_drops", o_trc_drops, 0);
        chk("t6_ovf", o_trc_ovf, 0);
        chk("t6_head", o_trc_seq, 1);
        instr(16'h0309, 0, 0, 0, 0, 0, 0, 0, vpre);
        chk("t6_stillfull", o_trc_drops, 1);
        chk("t6_ovf2", o_trc_ovf, 1);
        i_trc_rst_n = 0; step(); i_trc_rst_n = 1;
        chk("t6_rst_vld", o_trc_vld, 0);
        chk("t6_rst_ovf", o_trc_ovf, 0);
        chk("t6_rst_drops", o_trc_drops, 0);
        instr(16'h0400, 0, 0, 0, 0, 0, 0, 0, vpre);
        chk("t6_seq0", o_trc_seq, 0);
        chk("t6_pc", o_trc_pc, 16'h0400);

        // drop counter saturates
        do_reset();
        for (int i = 0; i < 268; i++) instr(16'h0500, 0, 0, 0, 0, 0, 0, 0, vpre);
        chk("t7_sat", o_trc_drops, 255);
        chk("t7_ovf", o_trc_ovf, 1);
        chk("t7_head", o_trc_seq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
